// File: rtl/alu_cmd_pipe.sv
// Command FIFO feeding an external 4-bit ALU; the result is registered one edge after the command reaches the FIFO head.
// Valid/ready on both sides: in_ready is set by FIFO occupancy only, and a stalled result holds every out_* field stable.

module alu_cmd_pipe_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
endmodule

module alu_cmd_pipe #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_sel,
  input  logic [3:0]    in_a,
  input  logic [3:0]    in_b,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [3:0]    alu_out,
  input  logic          alu_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_result,
  output logic          out_carry,
  output logic          out_zero,
  output logic [2:0]    out_sel,
  output logic [CW-1:0] count,
  output logic          busy
);
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  cmd_t             w_in_cmd;
  cmd_t             w_head;
  logic [CMD_W-1:0] w_head_dat;
  logic [CW-1:0]    w_count;
  logic             w_empty;
  logic             w_push;
  logic             w_cap;
  logic             w_arith;

  logic             r_out_valid;
  logic [3:0]       r_out_result;
  logic             r_out_carry;
  logic             r_out_zero;
  logic [2:0]       r_out_sel;

  assign w_in_cmd = '{sel: in_sel, a: in_a, b: in_b};
  assign in_ready = (w_count < FULL_CNT);
  assign w_push   = in_valid && in_ready;
  // Pop when the head has somewhere to go: output slot empty or being drained.
  assign w_cap    = !w_empty && (!r_out_valid || out_ready);

  alu_cmd_pipe_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_in_cmd),
    .i_pop   (w_cap),
    .o_dat   (w_head_dat),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_head  = w_head_dat;
  assign alu_a   = w_empty ? 4'd0 : w_head.a;
  assign alu_b   = w_empty ? 4'd0 : w_head.b;
  assign alu_sel = w_empty ? 3'd0 : w_head.sel;
  // Only add (000) and sub (001) produce a meaningful CarryOut.
  assign w_arith = (w_head.sel[2:1] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 4'd0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_sel    <= 3'd0;
    end else if (w_cap) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_out;
      r_out_carry  <= w_arith ? alu_carry : 1'b0;
      r_out_zero   <= (alu_out == 4'd0);
      r_out_sel    <= w_head.sel;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_sel    = r_out_sel;
  assign count      = w_count;
  assign busy       = !w_empty || r_out_valid;
endmodule
